// File: rtl/param_sorter_pkg.sv
// Shared types and constants for the in-place bubble sorter.
package param_sorter_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        LD_A,
        RD_B,
        CMP,
        SWAP_LO,
        SWAP_HI,
        PASS_END,
        DONE
    } state_e;

    localparam int unsigned SWAP_CNT_W = 32;

endpackage

// File: rtl/param_sorter_cmp.sv
// Combinational out-of-order test for one adjacent pair: A is the lower
// address, B the higher. Equal keys are never reported as out of order.
module sort_cmp #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned KEY_SIGNED = 0
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              descending_i,
    output logic              out_of_order_o
);

    logic a_gt_b;
    logic b_gt_a;

    generate
        if (KEY_SIGNED != 0) begin : g_signed
            assign a_gt_b = $signed(a_i) > $signed(b_i);
            assign b_gt_a = $signed(b_i) > $signed(a_i);
        end else begin : g_unsigned
            assign a_gt_b = a_i > b_i;
            assign b_gt_a = b_i > a_i;
        end
    endgenerate

    assign out_of_order_o = descending_i ? b_gt_a : a_gt_b;

endmodule

// File: rtl/param_sorter.sv
// In-place early-exit bubble sort over the first `length` words of a
// single-port synchronous RAM. Optional swap counter: PARAM_SORTER_SWAP_COUNT_EN.
module param_sorter
    import param_sorter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned KEY_SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] length,
    input  logic              descending,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              we
`ifdef PARAM_SORTER_SWAP_COUNT_EN
    ,
    output logic [SWAP_CNT_W-1:0] swap_count
`endif
);

    state_e              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [ADDR_W-1:0]   limit_q;
    logic                swapped_q;
    logic                desc_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_in_q;
    logic                we_q;
    logic                out_of_order;

    sort_cmp #(
        .DATA_W    (DATA_W),
        .KEY_SIGNED(KEY_SIGNED)
    ) u_cmp (
        .a_i           (a_q),
        .b_i           (data_out),
        .descending_i  (desc_q),
        .out_of_order_o(out_of_order)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            limit_q   <= '0;
            swapped_q <= 1'b0;
            desc_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_in_q <= '0;
            we_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        desc_q <= descending;
                        if (length <= ADDR_W'(1)) begin
                            state_q <= DONE;
                        end else begin
                            limit_q   <= length - ADDR_W'(1);
                            swapped_q <= 1'b0;
                            addr_q    <= '0;
                            state_q   <= RD_A;
                        end
                    end
                end
                RD_A: state_q <= LD_A;
                LD_A: begin
                    a_q     <= data_out;
                    addr_q  <= addr_q + ADDR_W'(1);
                    state_q <= RD_B;
                end
                RD_B: state_q <= CMP;
                CMP: begin
                    if (out_of_order) begin
                        we_q      <= 1'b1;
                        addr_q    <= addr_q - ADDR_W'(1);
                        data_in_q <= data_out;
                        swapped_q <= 1'b1;
                        state_q   <= SWAP_LO;
                    end else begin
                        a_q <= data_out;
                        if (addr_q == limit_q) begin
                            state_q <= PASS_END;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= RD_B;
                        end
                    end
                end
                // The larger (or smaller, descending) element keeps riding up
                // the array, so A is left untouched across the swap.
                SWAP_LO: begin
                    addr_q    <= addr_q + ADDR_W'(1);
                    data_in_q <= a_q;
                    state_q   <= SWAP_HI;
                end
                SWAP_HI: begin
                    we_q <= 1'b0;
                    if (addr_q == limit_q) begin
                        state_q <= PASS_END;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= RD_B;
                    end
                end
                PASS_END: begin
                    if (!swapped_q || limit_q == ADDR_W'(1)) begin
                        state_q <= DONE;
                    end else begin
                        limit_q   <= limit_q - ADDR_W'(1);
                        swapped_q <= 1'b0;
                        addr_q    <= '0;
                        state_q   <= RD_A;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign addr    = addr_q;
    assign data_in = data_in_q;
    assign we      = we_q;

`ifdef PARAM_SORTER_SWAP_COUNT_EN
    logic [SWAP_CNT_W-1:0] swap_cnt_q;
    logic [SWAP_CNT_W-1:0] swap_cnt_d;

    // NOTE: the default assignment first keeps this always_comb latch-free.
    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (state_q == IDLE && go) begin
            swap_cnt_d = '0;
        end else if (state_q == CMP && out_of_order && swap_cnt_q != '1) begin
            swap_cnt_d = swap_cnt_q + SWAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_cnt_q <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign swap_count = swap_cnt_q;
`endif

endmodule

// File: tb/tb_param_sorter.sv
// Scoreboard bench for param_sorter: an unsigned and a signed instance, each
// with its own behavioural RAM; expected results are queued per run.
module tb_param_sorter;

    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        string       name;
        logic [63:0] mem;
        int          cyc;
        int          writes;
        int          swaps;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          go, go_s;
    logic [AW-1:0] length;
    logic          descending;

    logic          busy, done, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in, data_out;
    logic          busy_s, done_s, we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] data_in_s, data_out_s;
`ifdef PARAM_SORTER_SWAP_COUNT_EN
    logic [31:0]   swap_count, swap_count_s;
`endif

    logic [DW-1:0] mem   [16];
    logic [DW-1:0] mem_s [16];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    exp_t q_u[$];
    exp_t q_s[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_sorter #(.DATA_W(DW), .ADDR_W(AW), .KEY_SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .go(go), .length(length), .descending(descending),
        .busy(busy), .done(done), .addr(addr), .data_in(data_in), .data_out(data_out),
        .we(we)
`ifdef PARAM_SORTER_SWAP_COUNT_EN
        , .swap_count(swap_count)
`endif
    );

    param_sorter #(.DATA_W(DW), .ADDR_W(AW), .KEY_SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .go(go_s), .length(length), .descending(descending),
        .busy(busy_s), .done(done_s), .addr(addr_s), .data_in(data_in_s),
        .data_out(data_out_s), .we(we_s)
`ifdef PARAM_SORTER_SWAP_COUNT_EN
        , .swap_count(swap_count_s)
`endif
    );

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr]   <= ld_data;
            mem_s[ld_addr] <= ld_data;
        end else begin
            if (we)   mem[addr]     <= data_in;
            if (we_s) mem_s[addr_s] <= data_in_s;
        end
        data_out   <= mem[addr];
        data_out_s <= mem_s[addr_s];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [63:0] m,
                                input int cyc, input int writes, input int swaps);
        exp_t e;
        e.name = name; e.mem = m; e.cyc = cyc; e.writes = writes; e.swaps = swaps;
        return e;
    endfunction

    // Word 0 lands in the least significant byte.
    function automatic logic [63:0] pk(input logic [7:0] w0, input logic [7:0] w1,
                                       input logic [7:0] w2, input logic [7:0] w3);
        return {32'h0, w3, w2, w1, w0};
    endfunction

    // Unsigned-instance monitor: cycle 0 is the edge that raised busy.
    int   cyc_u, wr_u;
    logic busy_up, done_up;
    always @(negedge clk) begin
        if (!reset) begin
            cyc_u = 0; wr_u = 0; busy_up = 1'b0; done_up = 1'b0;
        end else begin
            if (busy && !busy_up) begin
                cyc_u = 0; wr_u = 0;
            end else begin
                cyc_u++;
            end
            if (we) wr_u++;
            if (done && !done_up) begin
                if (q_u.size() == 0) begin
                    check("unexpected_done", 64'(q_u.size()), 64'd1);
                end else begin
                    exp_t e;
                    logic [63:0] got;
                    e = q_u.pop_front();
                    for (int i = 0; i < 8; i++) got[8*i +: 8] = mem[i];
                    check({e.name, "_mem"}, got, e.mem);
                    check({e.name, "_done_cycle"}, 64'(cyc_u + 1), 64'(e.cyc));
                    check({e.name, "_writes"}, 64'(wr_u), 64'(e.writes));
                    check({e.name, "_busy_done_excl"}, {63'd0, busy}, 64'd0);
`ifdef PARAM_SORTER_SWAP_COUNT_EN
                    check({e.name, "_swaps"}, 64'(swap_count), 64'(e.swaps));
`endif
                end
            end
            busy_up = busy; done_up = done;
        end
    end

    int   cyc_s, wr_s;
    logic busy_sp, done_sp;
    always @(negedge clk) begin
        if (!reset) begin
            cyc_s = 0; wr_s = 0; busy_sp = 1'b0; done_sp = 1'b0;
        end else begin
            if (busy_s && !busy_sp) begin
                cyc_s = 0; wr_s = 0;
            end else begin
                cyc_s++;
            end
            if (we_s) wr_s++;
            if (done_s && !done_sp) begin
                if (q_s.size() == 0) begin
                    check("unexpected_done_s", 64'(q_s.size()), 64'd1);
                end else begin
                    exp_t e;
                    logic [63:0] got;
                    e = q_s.pop_front();
                    for (int i = 0; i < 8; i++) got[8*i +: 8] = mem_s[i];
                    check({e.name, "_mem"}, got, e.mem);
                    check({e.name, "_done_cycle"}, 64'(cyc_s + 1), 64'(e.cyc));
                    check({e.name, "_writes"}, 64'(wr_s), 64'(e.writes));
`ifdef PARAM_SORTER_SWAP_COUNT_EN
                    check({e.name, "_swaps"}, 64'(swap_count_s), 64'(e.swaps));
`endif
                end
            end
            busy_sp = busy_s; done_sp = done_s;
        end
    end

    task automatic load(input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = v[8*i +: 8];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run(input exp_t e, input logic [63:0] init, input int n,
                       input bit desc, input bit on_s, input bit poke);
        int t;
        int pending;
        load(init);
        if (on_s) q_s.push_back(e); else q_u.push_back(e);
        @(negedge clk);
        length = AW'(n); descending = desc;
        if (on_s) go_s = 1'b1; else go = 1'b1;
        @(negedge clk);
        go = 1'b0; go_s = 1'b0;
        if (poke) begin
            repeat (4) @(negedge clk);
            check({e.name, "_busy_mid"}, {63'd0, busy}, 64'd1);
            go = 1'b1; length = AW'(2); descending = ~desc;
            @(negedge clk);
            go = 1'b0;
        end
        t = 0;
        pending = on_s ? q_s.size() : q_u.size();
        while (pending != 0 && t < 1000) begin
            @(negedge clk);
            t++;
            pending = on_s ? q_s.size() : q_u.size();
        end
        check({e.name, "_timeout"}, 64'(pending), 64'd0);
        if (pending != 0) begin
            q_u.delete(); q_s.delete();
        end
    endtask

    initial begin
        int t;
        reset = 1'b0; go = 1'b0; go_s = 1'b0; length = '0; descending = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_we", {63'd0, we}, 64'd0);
        check("reset_addr", 64'(addr), 64'd0);
        check("reset_data_in", 64'(data_in), 64'd0);
`ifdef PARAM_SORTER_SWAP_COUNT_EN
        check("reset_swap_count", 64'(swap_count), 64'd0);
`endif
        reset = 1'b1;

        run(mk("mix_asc", pk(0, 1, 2, 3), 33, 10, 5), pk(3, 1, 2, 0), 4, 1'b0, 1'b0, 1'b0);
        run(mk("presorted", pk(1, 2, 3, 4), 11, 0, 0), pk(1, 2, 3, 4), 4, 1'b0, 1'b0, 1'b0);
        run(mk("desc3", pk(3, 2, 1, 0), 20, 6, 3), pk(1, 2, 3, 0), 3, 1'b1, 1'b0, 1'b0);
        run(mk("equal", pk(5, 5, 0, 0), 7, 0, 0), pk(5, 5, 0, 0), 2, 1'b0, 1'b0, 1'b0);
        run(mk("len0", pk(9, 8, 7, 6), 2, 0, 0), pk(9, 8, 7, 6), 0, 1'b0, 1'b0, 1'b0);
        run(mk("len1", pk(9, 8, 7, 6), 2, 0, 0), pk(9, 8, 7, 6), 1, 1'b0, 1'b0, 1'b0);
        run(mk("unsigned_key", pk(8'h01, 8'h80, 0, 0), 9, 2, 1), pk(8'h80, 8'h01, 0, 0),
            2, 1'b0, 1'b0, 1'b0);
        run(mk("signed_key", pk(8'h80, 8'h01, 0, 0), 7, 0, 0), pk(8'h80, 8'h01, 0, 0),
            2, 1'b0, 1'b1, 1'b0);

        // Abort a run in SWAP_HI: wait for the first write (SWAP_LO), one more edge.
        load(pk(3, 1, 2, 0));
        @(negedge clk);
        length = AW'(4); descending = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        t = 0;
        while (!we && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("abort_saw_write", {63'd0, we}, 64'd1);
        @(posedge clk);
        #2;
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        check("abort_we", {63'd0, we}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_addr", 64'(addr), 64'd0);
        check("abort_data_in", 64'(data_in), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run(mk("post_reset", pk(1, 2, 3, 4), 35, 12, 6), pk(4, 3, 2, 1), 4, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

endmodule
